// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers ALU commands in a small FIFO, drives one command
// at a time into an external combinational ALU, captures the result and
// flags, and returns them over a valid/ready response channel. A 4-bit
// accumulator holds the last result so commands can chain on it.
module alu_cmd_issuer #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic       cmd_use_acc,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_mod,
  input  logic [3:0] alu_result,
  input  logic       alu_zero,
  input  logic       alu_c,
  input  logic       alu_of,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_result,
  output logic [2:0] rsp_flags,
  output logic [3:0] rsp_seq,
  output logic [3:0] acc
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  // One FIFO entry: {op, a, b, use_acc}
  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       use_acc;
  } cmd_t;

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  state_t        state_q, state_d;

  logic [3:0] alu_a_q, alu_b_q;
  logic [2:0] alu_mod_q;
  logic       rsp_valid_q;
  logic [3:0] rsp_result_q, rsp_seq_q, acc_q;
  logic [2:0] rsp_flags_q;

  logic push, pop, capture, rsp_done;
  logic fifo_nonempty;
  cmd_t head, wr_entry;

  assign fifo_nonempty = (count_q != '0);
  assign cmd_ready     = (count_q < FULL_CNT);
  assign push          = cmd_valid & cmd_ready;
  assign head          = mem_q[rd_ptr_q];
  assign wr_entry      = '{op: cmd_op, a: cmd_a, b: cmd_b, use_acc: cmd_use_acc};

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_mod    = alu_mod_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_seq    = rsp_seq_q;
  assign acc        = acc_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: ISSUE always lasts one cycle; RESP waits for the handshake
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fifo_nonempty) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    if (rsp_ready) state_d = fifo_nonempty ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control strobes decoded from the current state
  always_comb begin
    pop      = 1'b0;
    capture  = 1'b0;
    rsp_done = 1'b0;
    unique case (state_q)
      IDLE:    pop = fifo_nonempty;
      ISSUE:   capture = 1'b1;
      RESP: begin
        rsp_done = rsp_ready;
        pop      = rsp_ready & fifo_nonempty;
      end
      default: ;
    endcase
  end

  // FIFO storage; a push always lands here first and is never bypassed
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // ALU operand registers: loaded only when a command is popped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_mod_q <= '0;
    end else if (pop) begin
      alu_mod_q <= head.op;
      alu_b_q   <= head.b;
      alu_a_q   <= head.use_acc ? acc_q : head.a;
    end
  end

  // Response and accumulator: capture at the end of ISSUE, retire on handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_seq_q    <= '0;
      acc_q        <= '0;
    end else begin
      if (capture) begin
        rsp_result_q <= alu_result;
        rsp_flags_q  <= {alu_c, alu_zero, alu_of};
        acc_q        <= alu_result;
        rsp_valid_q  <= 1'b1;
      end else if (rsp_done) begin
        rsp_valid_q <= 1'b0;
        rsp_seq_q   <= rsp_seq_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: a stand-in combinational ALU, a transaction-level
// reference model (command queue + accumulator + sequence counter) checked
// on every response handshake, and directed scenarios with literal values.
module tb_alu_cmd_issuer;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid, cmd_ready, cmd_use_acc;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a, cmd_b;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_mod;
  logic       alu_zero, alu_c, alu_of;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_result, rsp_seq, acc;
  logic [2:0] rsp_flags;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mod(alu_mod),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_c(alu_c), .alu_of(alu_of),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_seq(rsp_seq), .acc(acc)
  );

  // 4-bit ALU behaviour; returns {C, zero, overflow, result}
  function automatic logic [6:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] r;
    logic c, of;
    c = 1'b0; of = 1'b0; r = '0; s = '0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4];
                  of = (a[3] == b[3]) && (r[3] != a[3]); end
      3'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = s[4];
                  of = (a[3] != b[3]) && (r[3] != a[3]); end
      3'd2: begin r = 4'd0 - a; c = (a != 4'd0); of = (a == 4'd8); end
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = ($signed(a) < $signed(b)) ? 4'd1 : 4'd0;
      default: r = (a == b) ? 4'd1 : 4'd0;
    endcase
    return {c, (r == 4'd0), of, r};
  endfunction

  logic [6:0] alu_out;
  assign alu_out    = alu_f(alu_mod, alu_a, alu_b);
  assign alu_result = alu_out[3:0];
  assign alu_of     = alu_out[4];
  assign alu_zero   = alu_out[5];
  assign alu_c      = alu_out[6];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       ua;
  } cmd_t;
  cmd_t       q[$];
  logic [3:0] macc = '0;
  logic [3:0] mseq = '0;
  int         n_rsp = 0;
  logic [3:0] last_res, last_seq;
  logic [2:0] last_flags;
  bit         prev_hold = 0;
  logic [3:0] p_res, p_seq;
  logic [2:0] p_flags;

  // Compare process: stable hold while backpressured, and full check on each handshake
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      macc = '0;
      mseq = '0;
      prev_hold = 0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", rsp_valid, 1);
        chk("hold_result", rsp_result, p_res);
        chk("hold_flags", rsp_flags, p_flags);
        chk("hold_seq", rsp_seq, p_seq);
      end
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          chk("spurious_rsp", 1, 0);
        end else begin
          cmd_t c;
          logic [3:0] ea;
          logic [6:0] e;
          c  = q.pop_front();
          ea = c.ua ? macc : c.a;
          e  = alu_f(c.op, ea, c.b);
          chk("rsp_result", rsp_result, e[3:0]);
          chk("rsp_flags", rsp_flags, {e[6], e[5], e[4]});
          chk("rsp_seq", rsp_seq, mseq);
          chk("acc", acc, e[3:0]);
          chk("alu_a", alu_a, ea);
          chk("alu_b", alu_b, c.b);
          chk("alu_mod", alu_mod, c.op);
          macc = e[3:0];
          mseq = mseq + 4'd1;
          last_res = rsp_result; last_seq = rsp_seq; last_flags = rsp_flags;
          n_rsp++;
        end
      end
      if (cmd_valid && cmd_ready)
        q.push_back('{op: cmd_op, a: cmd_a, b: cmd_b, ua: cmd_use_acc});
      prev_hold = rsp_valid && !rsp_ready;
      p_res = rsp_result; p_seq = rsp_seq; p_flags = rsp_flags;
    end
  end

  task automatic set_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic ua);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua;
  endtask

  // Present one command and return one step after the edge that accepts it
  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic ua);
    bit done;
    done = 0;
    set_cmd(op, a, b, ua);
    cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    cmd_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_rsp(input int n);
    bit done;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (n_rsp >= n) done = 1;
      else @(negedge clk);
    end
    if (!done) chk("rsp_timeout", n_rsp, n);
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Hold cmd_valid with fresh commands and count how many get accepted in a window
  task automatic fill(input int want, input int cycles, output int got);
    got = 0;
    set_cmd(3'd0, 4'd1, 4'd1, 1'b0);
    cmd_valid = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (cmd_ready && got < want) begin
        @(posedge clk); #1;
        got++;
        if (got == want) cmd_valid = 1'b0;
        else set_cmd(3'd0, 4'(got + 1), 4'd1, 1'b0);
      end
    end
  endtask

  int base, got;

  initial begin
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    set_cmd(3'd0, 4'd0, 4'd0, 1'b0);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_flags", rsp_flags, 0);
    chk("rst_rsp_seq", rsp_seq, 0);
    chk("rst_acc", acc, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_mod", alu_mod, 0);
    rst = 1'b0;

    // Single add and latency: accepted at E0, pop at E1, valid after E2, one cycle wide
    send(3'd0, 4'd3, 4'd4, 1'b0);
    @(negedge clk); chk("lat_after_e0", rsp_valid, 0);
    @(negedge clk); chk("lat_after_e1", rsp_valid, 0);
    @(negedge clk); chk("lat_after_e2", rsp_valid, 1);
    chk("add_result", rsp_result, 7);
    chk("add_flags", rsp_flags, 0);
    chk("add_seq", rsp_seq, 0);
    chk("add_acc", acc, 7);
    @(negedge clk); chk("lat_one_cycle", rsp_valid, 0);

    // Accumulator chain: 7 then 7+2 = 9 with signed overflow
    do_reset();
    base = n_rsp;
    send(3'd0, 4'd3, 4'd4, 1'b0);
    send(3'd0, 4'd0, 4'd2, 1'b1);
    wait_rsp(base + 2);
    chk("chain_result", last_res, 9);
    chk("chain_flags", last_flags, 3'b001);
    chk("chain_seq", last_seq, 1);

    // Backpressure: 1 in RESP + DEPTH in FIFO accepted, then stall
    do_reset();
    base = n_rsp;
    rsp_ready = 1'b0;
    fill(6, 30, got);
    chk("full_accepted", got, DEPTH + 1);
    chk("full_cmd_ready", cmd_ready, 0);
    chk("full_hold_result", rsp_result, 2);
    chk("full_hold_seq", rsp_seq, 0);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_rsp(base + DEPTH + 1);
    chk("full_last_seq", last_seq, 4);
    chk("full_last_result", last_res, 6);

    // Simultaneous push and RESP handshake with two entries queued
    do_reset();
    base = n_rsp;
    rsp_ready = 1'b0;
    send(3'd5, 4'd1, 4'd1, 1'b0);
    send(3'd5, 4'd9, 4'd2, 1'b0);
    send(3'd5, 4'd10, 4'd3, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("pp_in_resp", rsp_valid, 1);
    set_cmd(3'd3, 4'd15, 4'd12, 1'b0);
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("pp_alu_a_old_head", alu_a, 9);
    chk("pp_alu_b_old_head", alu_b, 2);
    // Count is still 2: exactly two more fit while the pipeline is stalled
    fill(4, 20, got);
    chk("pp_count_kept", got, 2);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_rsp(base + 6);

    // Asynchronous reset in the middle of ISSUE
    do_reset();
    base = n_rsp;
    send(3'd0, 4'd3, 4'd4, 1'b0);
    wait_rsp(base + 1);
    send(3'd5, 4'd5, 4'd3, 1'b0);
    @(posedge clk); #1;
    chk("ar_issue_alu_a", alu_a, 5);
    #2 rst = 1'b1;
    #1;
    chk("ar_rsp_valid", rsp_valid, 0);
    chk("ar_acc", acc, 0);
    chk("ar_alu_a", alu_a, 0);
    chk("ar_alu_b", alu_b, 0);
    chk("ar_alu_mod", alu_mod, 0);
    chk("ar_cmd_ready", cmd_ready, 1);
    @(negedge clk); #1 rst = 1'b0;
    base = n_rsp;
    send(3'd0, 4'd1, 4'd1, 1'b0);
    wait_rsp(base + 1);
    chk("ar_seq_restart", last_seq, 0);
    chk("ar_result", last_res, 2);

    // Sequence wrap over 17 responses
    do_reset();
    base = n_rsp;
    for (int k = 0; k < 17; k++) send(3'd4, 4'(k), 4'd0, 1'b0);
    wait_rsp(base + 17);
    chk("wrap_seq", last_seq, 0);
    chk("wrap_result", last_res, 0);

    // Random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      set_cmd(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 1'($urandom));
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 100 && (q.size() != 0 || rsp_valid); i++) @(negedge clk);
    chk("rand_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Sequential initiator that feeds the 4-bit combinational ALU (`A`, `B`, `mod` → `result`, `zero`, `C`, `overflow`) from a buffered command stream. It returns each captured result with its flags over a valid/ready response channel. It holds a 4-bit accumulator so that commands can chain on the previous result. It sits between a command producer (test harness or future control FSM) and the ALU instance.

## Interface
- `DEPTH`, default 4: command FIFO entries; power of 2, ≥2.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept; high exactly when FIFO count < DEPTH.
- `cmd_op`  in  3  ALU mod code: 000 add, 001 sub, 010 neg, 011 and, 100 or, 101 xor, 110 less-than, 111 equal.
- `cmd_a`  in  4  operand A; ignored when `cmd_use_acc`=1.
- `cmd_b`  in  4  operand B.
- `cmd_use_acc`  in  1  1: operand A is the accumulator value at issue time.
- `alu_a`, `alu_b`  out  4  to ALU `A`, `B`; registered.
- `alu_mod`  out  3  to ALU `mod`; registered.
- `alu_result`  in  4  from ALU `result`.
- `alu_zero`, `alu_c`, `alu_of`  in  1  from ALU `zero`, `C`, `overflow`.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts.
- `rsp_result`  out  4  captured ALU result.
- `rsp_flags`  out  3  {C, zero, overflow} captured with the result.
- `rsp_seq`  out  4  sequence number of this response; first response after reset is 0; wraps 15→0.
- `acc`  out  4  current accumulator.

## Operation
- A command is accepted on any edge with `cmd_valid & cmd_ready` and is written at the FIFO tail. Fields stored: op, a, b, use_acc.
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if FIFO count > 0, pop the head at the edge and go to ISSUE. Load `alu_mod`←op, `alu_b`←b, `alu_a`←(use_acc ? acc : a). Otherwise stay in IDLE.
- ISSUE: lasts exactly one cycle with ALU inputs stable. At its closing edge:
  - `rsp_result`←`alu_result` and `rsp_flags`←{`alu_c`,`alu_zero`,`alu_of`}.
  - `acc`←`alu_result` for every op.
  - `rsp_valid`←1; go to RESP.
- RESP: `rsp_valid`=1 and all `rsp_*` outputs are held stable until `rsp_ready`=1. On the handshake edge:
  - `rsp_seq` increments.
  - If FIFO count > 0, pop and load ALU regs as in IDLE and go directly to ISSUE.
  - Otherwise go to IDLE.
  - In both cases `rsp_valid`←0.
- `alu_a`/`alu_b`/`alu_mod` change only on a pop edge and hold their last values otherwise.
- Simultaneous push and pop: count unchanged; both take effect. A push never bypasses an empty FIFO: it is always written first and popped on a later edge.
- When use_acc=1, the accumulator is sampled at the pop edge. That value is always the result of the previously completed command, because capture precedes the next pop by at least one edge.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.

## Timing
- Reset values: state IDLE, FIFO empty, `cmd_ready`=1, `rsp_valid`=0, `rsp_result`=0, `rsp_flags`=0, `rsp_seq`=0, `acc`=0, `alu_a`=`alu_b`=0, `alu_mod`=0.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge. Any in-flight or unacknowledged response is discarded.
- Latency, with the block idle and FIFO empty: command accepted at edge E0 → pop at E1 → `rsp_valid` high after E2.
- Throughput with `rsp_ready` held at 1: one response every 2 cycles.
- `cmd_ready` depends only on the registered count, so there is no combinational path from `rsp_ready`.
- No combinational path from `alu_*` inputs to any output. Everything is captured in ISSUE.

## Test plan
- Single add: cmd (000, a=3, b=4), `rsp_ready`=1 → `rsp_valid` is high for one cycle, 2 edges after acceptance, with `rsp_result`=7, flags=000, `rsp_seq`=0, `acc`=7.
- Accumulator chain: (000, 3, 4) then (000, use_acc=1, b=2) → responses 7 then 9 (1001); second response has overflow=1, `rsp_seq`=1.
- Backpressure and full FIFO: `rsp_ready`=0 while `cmd_valid` is held with 6 commands.
  - Required: 5 are accepted (1 in RESP + 4 in FIFO) and `cmd_ready`=0 for the 6th.
  - The first response stays stable throughout.
  - Releasing `rsp_ready` drains the responses in order, with `rsp_seq` 0..4.
- Simultaneous push/pop: with count=2, push on the same edge as a RESP handshake → count stays 2, and the next ALU inputs are the old FIFO head.
- Async reset mid-ISSUE: assert `rst` between edges → `rsp_valid`, `acc`, `alu_*` go to 0 and `cmd_ready`=1 before the next edge. After release, the next command yields `rsp_seq`=0.
- Sequence wrap: 17 back-to-back commands → `rsp_seq` goes 0..15, then 0.
